div_iter: RTL and testbench

- Sequential RV32M divider that implements DIV, DIVU, REM and REMU, which the combinational ALU does not handle.
- Sits beside the ALU in the execute stage. The pipeline launches an operation with a one-cycle start and stalls on busy until the one-cycle done pulse returns the result.
- Radix-2 restoring algorithm on operand magnitudes: one quotient bit per clock, sign fix-up at the end.
- RISC-V special cases (divide-by-zero, signed overflow) complete on a fast path.

---
 rtl/div_iter.sv | 189 ++++++++++++++++++
 tb/tb_div_iter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: sequential RV32M divider (DIV, DIVU, REM, REMU).
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// clock, with a sign fix-up step at the end. Divide-by-zero and signed
// overflow finish on a one-cycle fast path.
// Optional build macro: DIV_SMALL_BYPASS_EN. When it is defined, operations
// with |opa| < |opb| also take the fast path (quotient 0, remainder opa).
// The results are the same in both builds. Only the latency differs.
`timescale 1ns/1ps

module div_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_r;
    logic              busy_r;
    logic              done_r;
    logic [XLEN-1:0]   result_r;
    logic [XLEN-1:0]   rem_r;      // partial remainder
    logic [XLEN-1:0]   quo_r;      // dividend bits shift out, quotient bits shift in
    logic [XLEN-1:0]   div_r;      // divisor magnitude
    logic              neg_q_r;
    logic              neg_r_r;
    logic              sel_rem_r;
    logic [CNT_W-1:0]  count_r;

    // Two's-complement negation, also used to take magnitudes.
    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return (~x) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // funct3[2] is always 1 for M-extension divides and carries no information here.
    logic unused_f3_s;
    assign unused_f3_s = funct3[2];

    logic            signed_op_s;
    logic            sign_a_s;
    logic            sign_b_s;
    logic [XLEN-1:0] mag_a_s;
    logic [XLEN-1:0] mag_b_s;
    logic            div_zero_s;
    logic            ovf_s;
    logic            bypass_s;
    logic            fast_s;
    logic [XLEN-1:0] fast_res_s;
    logic            ready_s;

    // Decode the launch operands: magnitudes, signs and the fast-path result.
    always_comb begin
        signed_op_s = ~funct3[0];
        sign_a_s    = signed_op_s & opa[XLEN-1];
        sign_b_s    = signed_op_s & opb[XLEN-1];
        mag_a_s     = sign_a_s ? negate(opa) : opa;
        mag_b_s     = sign_b_s ? negate(opb) : opb;
        div_zero_s  = (opb == {XLEN{1'b0}});
        ovf_s       = signed_op_s
                      && (opa == {1'b1, {(XLEN-1){1'b0}}})
                      && (opb == {XLEN{1'b1}});
`ifdef DIV_SMALL_BYPASS_EN
        bypass_s    = (!div_zero_s) && (!ovf_s) && (mag_a_s < mag_b_s);
`else
        bypass_s    = 1'b0;
`endif
        fast_s      = div_zero_s | ovf_s | bypass_s;
        if (div_zero_s) begin
            fast_res_s = funct3[1] ? opa : {XLEN{1'b1}};
        end else if (ovf_s) begin
            // The quotient saturates to the dividend (0x80000000). The remainder is 0.
            fast_res_s = funct3[1] ? {XLEN{1'b0}} : opa;
        end else if (bypass_s) begin
            fast_res_s = funct3[1] ? opa : {XLEN{1'b0}};
        end else begin
            fast_res_s = {XLEN{1'b0}};
        end
        ready_s     = (state_r == IDLE) || (state_r == DONE);
    end

    logic [XLEN:0]   shift_s;
    logic [XLEN:0]   diff_s;
    logic            ge_s;
    logic [XLEN-1:0] rem_next_s;
    logic [XLEN-1:0] q_fix_s;
    logic [XLEN-1:0] r_fix_s;

    // One restoring iteration, followed by the final sign fix-up.
    always_comb begin
        shift_s    = {rem_r, quo_r[XLEN-1]};
        diff_s     = shift_s - {1'b0, div_r};
        ge_s       = (shift_s >= {1'b0, div_r});
        // When the trial subtraction succeeds, the difference is below the divisor and fits in XLEN bits.
        rem_next_s = ge_s ? diff_s[XLEN-1:0] : shift_s[XLEN-1:0];
        q_fix_s    = neg_q_r ? negate(quo_r) : quo_r;
        r_fix_s    = neg_r_r ? negate(rem_r) : rem_r;
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= {XLEN{1'b0}};
            rem_r     <= {XLEN{1'b0}};
            quo_r     <= {XLEN{1'b0}};
            div_r     <= {XLEN{1'b0}};
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            sel_rem_r <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
        end else if (flush) begin
            // Abort the operation. The result is kept and no done pulse is produced.
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start && ready_s) begin
                        sel_rem_r <= funct3[1];
                        if (fast_s) begin
                            result_r <= fast_res_s;
                            state_r  <= DONE;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                        end else begin
                            rem_r   <= {XLEN{1'b0}};
                            quo_r   <= mag_a_s;
                            div_r   <= mag_b_s;
                            neg_q_r <= sign_a_s ^ sign_b_s;
                            neg_r_r <= sign_a_s;
                            count_r <= {CNT_W{1'b0}};
                            state_r <= CALC;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                CALC: begin
                    rem_r   <= rem_next_s;
                    quo_r   <= {quo_r[XLEN-2:0], ge_s};
                    count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (count_r == {CNT_W{1'b1}}) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIX: begin
                    result_r <= sel_rem_r ? r_fix_s : q_fix_s;
                    state_r  <= DONE;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter. Stimulus pushes the expected result, and
// the edge offset at which done should rise, onto a queue. A monitor pops
// one entry per done pulse. A done that arrives with nothing expected is an error.
// Latency is counted in clock edges: done rises at edge E0+33 on the normal
// path and at edge E0 on the fast path, where E0 is the accepting edge.
`timescale 1ns/1ps

module tb_div_iter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] opa = 32'd0;
    logic [31:0] opb = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;
    localparam int LAT_N = 33;
    localparam int LAT_S = 0;
`ifdef DIV_SMALL_BYPASS_EN
    localparam int LAT_B = 0;
`else
    localparam int LAT_B = 33;
`endif

    div_iter #(.XLEN(32), .CNT_W(5)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .opa    (opa),
        .opb    (opb),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          e0;
        string       name;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Drive a one-cycle start and record the expected response against E0.
    task automatic issue(input bit now, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv, input int lat,
                         input string nm, input bit push);
        exp_t e;
        if (!now) @(negedge clock);
        funct3 = f3;
        opa    = a;
        opb    = b;
        start  = 1'b1;
        @(posedge clock);
        #1;
        e.res  = expv;
        e.lat  = lat;
        e.e0   = cyc;
        e.name = nm;
        if (push) sb.push_back(e);
        @(negedge clock);
        start  = 1'b0;
        funct3 = 3'b000;
        opa    = 32'hDEAD_BEEF;
        opb    = 32'h0000_0001;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d responses still pending", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clock);
                    if (reset && done) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_done: got result %h expected no done", result);
                        end else begin
                            e = sb.pop_front();
                            chk(e.name, result, e.res);
                            chk_int({e.name, "_lat"}, cyc - e.e0, e.lat);
                        end
                    end
                end
            end
        join_none

        // Reset state.
        repeat (2) @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Normal DIVU. busy must stay high through CALC and FIX. A start pulsed mid-flight is ignored.
        issue(1'b0, F_DIVU, 32'd100, 32'd7, 32'd14, LAT_N, "divu_100_7", 1'b1);
        begin
            int low = 0;
            for (int i = 0; i < 33; i++) begin
                if (!busy) low++;
                if (i == 5) begin
                    start = 1'b1; funct3 = F_DIV; opa = 32'd1; opb = 32'd0;
                end else begin
                    start = 1'b0;
                end
                @(negedge clock);
            end
            chk_int("busy_calc_fix_low_samples", low, 0);
        end
        wait_idle();

        issue(1'b0, F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_N, "div_m7_2", 1'b1);   wait_idle();
        issue(1'b0, F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_N, "rem_m7_2", 1'b1);   wait_idle();
        issue(1'b0, F_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1,         LAT_N, "remu_fff9_2", 1'b1); wait_idle();
        issue(1'b0, F_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, LAT_S, "div_5_0", 1'b1);  wait_idle();
        issue(1'b0, F_REM,  32'd5, 32'd0, 32'd5,         LAT_S, "rem_5_0", 1'b1);  wait_idle();
        issue(1'b0, F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_S, "div_ovf", 1'b1); wait_idle();
        issue(1'b0, F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_S, "rem_ovf", 1'b1); wait_idle();
        issue(1'b0, F_DIV,  32'h8000_0000, 32'd2, 32'hC000_0000, LAT_N, "div_min_2", 1'b1); wait_idle();
        issue(1'b0, F_REM,  32'h8000_0000, 32'd3, 32'hFFFF_FFFE, LAT_N, "rem_min_3", 1'b1); wait_idle();
        issue(1'b0, F_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_N, "div_7_m2", 1'b1);  wait_idle();
        issue(1'b0, F_REM,  32'd7, 32'hFFFF_FFFE, 32'd1,         LAT_N, "rem_7_m2", 1'b1);  wait_idle();
        issue(1'b0, F_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT_N, "divu_max_1", 1'b1); wait_idle();

        // Small-dividend cases. The values are the same in both builds; only the latency differs.
        issue(1'b0, F_DIV,  32'd3, 32'd10, 32'd0, LAT_B, "div_3_10", 1'b1); wait_idle();
        issue(1'b0, F_REM,  32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, LAT_B, "rem_m3_10", 1'b1); wait_idle();
        issue(1'b0, F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_B, "divu_min_max", 1'b1); wait_idle();
        issue(1'b0, F_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_B, "remu_min_max", 1'b1); wait_idle();

        // Reset in the middle of an operation. It must clear the outputs and no done may follow.
        issue(1'b0, F_DIVU, 32'd1000, 32'd3, 32'd0, 0, "aborted_rst", 1'b0);
        repeat (9) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);

        // Flush in the middle of an operation. The result is kept and no done may follow.
        issue(1'b0, F_DIVU, 32'd50, 32'd7, 32'd7, LAT_N, "divu_50_7", 1'b1); wait_idle();
        issue(1'b0, F_DIVU, 32'd1000, 32'd3, 32'd0, 0, "aborted_flush", 1'b0);
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_result_held", result, 32'd7);
        repeat (40) @(negedge clock);
        issue(1'b0, F_DIVU, 32'd9, 32'd3, 32'd3, LAT_N, "divu_9_3", 1'b1); wait_idle();

        // Back-to-back: a second start is raised in the DONE cycle of the first operation.
        issue(1'b0, F_DIVU, 32'd1000, 32'd3, 32'd333, LAT_N, "divu_1000_3", 1'b1);
        begin
            int n = 0;
            while (!done && n < 100) begin
                @(negedge clock);
                n++;
            end
            chk_int("b2b_first_done_seen", {31'd0, done}, 1);
        end
        issue(1'b1, F_REMU, 32'd17, 32'd5, 32'd2, LAT_N, "remu_17_5_b2b", 1'b1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
